// File: rtl/relay_symbol_tx_pkg.sv
// Shared relay-link definitions used by the relay transmitter.
//   - FSM state encodings (IDLE, SOF, DATA, PARITY, GAP)
//   - frame section lengths in half-cells
//   - relay mode constants (FAKE_TAG / FAKE_READER)
//   - even-parity helper for the optional parity bit
package relay_symbol_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SOF    = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  localparam int SOF_HALF_CELLS    = 4;
  localparam int DATA_HALF_CELLS   = 8;
  localparam int PARITY_HALF_CELLS = 2;
  localparam int GAP_HALF_CELLS    = 2;

  // speed_sel is driven high by the FAKE_READER select
  localparam logic MODE_FAKE_TAG    = 1'b0;
  localparam logic MODE_FAKE_READER = 1'b1;

  function automatic logic even_parity(input logic [3:0] sym);
    return ^sym;
  endfunction

endpackage

// File: rtl/relay_tx_fifo.sv
// Symbol FIFO for the relay transmitter: DEPTH x 4 bits, synchronous
// push/pop, asynchronous active-high reset of the pointers.
// Ports:
//   clk, reset          clock and async reset
//   push, wr_data       write request and data (ignored while full)
//   pop                 read request (ignored while empty)
//   rd_data             head-of-queue symbol
//   full, empty         occupancy flags, derived from registered pointers
module relay_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] wr_data,
  input  logic       pop,
  output logic [3:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // extra MSB on each pointer separates full from empty
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [3:0]  mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/relay_symbol_tx.sv
// Relay-link transmitter. Buffers 4-bit symbols from a valid/ready
// handshake and sends each as a Manchester frame on relay_out:
//   SOF (4 half-cells high) | DATA (4 bits MSB first, 1=HL 0=LH)
//   | [PARITY (1 bit, XOR of data)] | GAP (2 half-cells low)
// Optional feature macro: RELAY_TX_PARITY_EN adds the PARITY bit.
// Ports:
//   clk, reset                 clock and async active-high reset
//   data_in, data_in_valid     symbol input
//   data_in_ready              FIFO not full
//   speed_sel                  0 slow, 1 fast (half-cell halved), latched per frame
//   relay_out                  registered serial line, idle low
//   busy                       frame in progress or symbols queued
//
// state     | meaning
// IDLE      | line low, waiting for a queued symbol
// SOF       | line high for 4 half-cells (Manchester violation)
// DATA      | 4 Manchester bits from the shift register
// PARITY    | one Manchester parity bit (RELAY_TX_PARITY_EN only)
// GAP       | line low for 2 half-cells, may chain into next SOF
module relay_symbol_tx
  import relay_symbol_tx_pkg::*;
#(
  parameter int HALF_CELL_CLKS = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  input  logic       speed_sel,
  output logic       relay_out,
  output logic       busy
);

  localparam int TW = $clog2(HALF_CELL_CLKS);
  localparam logic [TW-1:0] RELOAD_SLOW = TW'(HALF_CELL_CLKS - 1);
  localparam logic [TW-1:0] RELOAD_FAST = TW'(HALF_CELL_CLKS / 2 - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    cells_left;
  logic [3:0]    shreg;
  logic          fast;
`ifdef RELAY_TX_PARITY_EN
  logic          par;
`endif

  logic [3:0] fifo_rd_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       half_end;
  logic       line;

  assign data_in_ready = !fifo_full;
  assign push          = data_in_valid && !fifo_full;
  assign half_end      = (timer == '0);
  assign busy          = (state != ST_IDLE) || !fifo_empty;

  // A new frame starts from IDLE, or straight out of the last GAP
  // half-cell so back-to-back frames have no idle cycle between them.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) ||
                (state == ST_GAP && half_end && cells_left == 3'd0));

  relay_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (data_in),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Odd cells_left is the first half of a Manchester bit.
  always_comb begin
    line = 1'b0;
    case (state)
      ST_SOF:    line = 1'b1;
      ST_DATA:   line = cells_left[0] ? shreg[3] : ~shreg[3];
`ifdef RELAY_TX_PARITY_EN
      ST_PARITY: line = cells_left[0] ? par : ~par;
`endif
      default:   line = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      cells_left <= '0;
      shreg      <= '0;
      fast       <= 1'b0;
      relay_out  <= 1'b0;
`ifdef RELAY_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      relay_out <= line;
      if (pop) begin
        state      <= ST_SOF;
        cells_left <= 3'(SOF_HALF_CELLS - 1);
        fast       <= speed_sel;
        timer      <= speed_sel ? RELOAD_FAST : RELOAD_SLOW;
        shreg      <= fifo_rd_data;
`ifdef RELAY_TX_PARITY_EN
        par        <= even_parity(fifo_rd_data);
`endif
      end else if (state != ST_IDLE) begin
        if (!half_end) begin
          timer <= timer - TIMER_ONE;
        end else begin
          timer <= fast ? RELOAD_FAST : RELOAD_SLOW;
          if (cells_left != 3'd0) begin
            cells_left <= cells_left - 3'd1;
            // advance to the next bit after its second half-cell
            if (state == ST_DATA && !cells_left[0])
              shreg <= {shreg[2:0], 1'b0};
          end else begin
            case (state)
              ST_SOF: begin
                state      <= ST_DATA;
                cells_left <= 3'(DATA_HALF_CELLS - 1);
              end
              ST_DATA: begin
`ifdef RELAY_TX_PARITY_EN
                state      <= ST_PARITY;
                cells_left <= 3'(PARITY_HALF_CELLS - 1);
`else
                state      <= ST_GAP;
                cells_left <= 3'(GAP_HALF_CELLS - 1);
`endif
              end
`ifdef RELAY_TX_PARITY_EN
              ST_PARITY: begin
                state      <= ST_GAP;
                cells_left <= 3'(GAP_HALF_CELLS - 1);
              end
`endif
              default: state <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_relay_symbol_tx.sv
// Self-checking bench for relay_symbol_tx with a frame-level reference model.
module tb_relay_symbol_tx;

  localparam int H     = 16;
  localparam int DEPTH = 4;
`ifdef RELAY_TX_PARITY_EN
  localparam int PAR_CELLS = 2;
`else
  localparam int PAR_CELLS = 0;
`endif
  localparam int HALF_TOTAL = 14 + PAR_CELLS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       speed_sel = 1'b0;
  logic       relay_out;
  logic       busy;

  int checks = 0;
  int failures = 0;

  relay_symbol_tx #(
    .HALF_CELL_CLKS(H),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .speed_sel     (speed_sel),
    .relay_out     (relay_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] q[$];
  int         frame_left = 0;
  logic [3:0] cur_sym = 4'h0;
  logic       cur_fast = 1'b0;
  logic       line_m = 1'b0;
  logic       relay_m = 1'b0;

  function automatic int frame_len(input logic f);
    return HALF_TOTAL * (f ? H / 2 : H);
  endfunction

  // Expected line level at clock 'pos' of a frame carrying 'sym'.
  function automatic logic frame_bit(input logic [3:0] sym, input logic f, input int pos);
    int hl;
    int h;
    logic v;
    hl = f ? H / 2 : H;
    h  = pos / hl;
    if (h < 4) return 1'b1;
    if (h < 12) begin
      v = sym[3 - (h - 4) / 2];
      return (((h - 4) % 2) == 0) ? v : ~v;
    end
    if (h < 12 + PAR_CELLS) begin
      v = ^sym;
      return (h == 12) ? v : ~v;
    end
    return 1'b0;
  endfunction

  function automatic logic busy_m();
    return (frame_left > 0) || (q.size() > 0);
  endfunction

  function automatic logic ready_m();
    return q.size() < DEPTH;
  endfunction

  task automatic model_reset();
    q.delete();
    frame_left = 0;
    line_m     = 1'b0;
    relay_m    = 1'b0;
  endtask

  // One clock: advance the model with the pre-edge inputs, then settle.
  task automatic tick(output logic pushed);
    logic rdy;
    @(posedge clk);
    rdy     = q.size() < DEPTH;
    pushed  = data_in_valid && rdy;
    relay_m = line_m;
    if (frame_left > 0) frame_left--;
    if (frame_left == 0 && q.size() > 0) begin
      cur_sym    = q.pop_front();
      cur_fast   = speed_sel;
      frame_left = frame_len(cur_fast);
    end
    if (pushed) q.push_back(data_in);
    line_m = (frame_left > 0) ?
             frame_bit(cur_sym, cur_fast, frame_len(cur_fast) - frame_left) : 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++; if (relay_out !== 1'b0) begin failures++; $display("FAIL reset_relay got=%b exp=0", relay_out); end
    checks++; if (data_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", data_in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    logic p;
    data_in_valid = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      data_in = 4'($urandom);
      tick(p);
      checks++; if (relay_out !== 1'b0) begin failures++; $display("FAIL idle_relay t=%0d got=%b exp=0", t, relay_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy t=%0d got=%b exp=0", t, busy); end
      checks++; if (data_in_ready !== 1'b1) begin failures++; $display("FAIL idle_ready t=%0d got=%b exp=1", t, data_in_ready); end
    end
  endtask

  // Single frame; checks rise latency, SOF width, data pattern, end of busy.
  task automatic test_single(input string name, input logic [3:0] sym, input logic spd,
                             input logic toggle, input logic [7:0] exp_pat);
    logic p;
    int hl, first_high, high_run, fall;
    logic [7:0] pat;
    logic [1:0] ppat;
    hl = spd ? H / 2 : H;
    first_high = -1; high_run = 0; fall = -1; pat = '0; ppat = '0;
    data_in = sym; speed_sel = spd; data_in_valid = 1'b1;
    tick(p);
    data_in_valid = 1'b0;
    checks++; if (p !== 1'b1) begin failures++; $display("FAIL %s_handshake got=%b exp=1", name, p); end
    for (int t = 1; t < 400; t++) begin
      if (toggle && (t % 10 == 0)) speed_sel = ~speed_sel;
      tick(p);
      checks++; if (relay_out !== relay_m) begin failures++; $display("FAIL %s_relay t=%0d got=%b exp=%b", name, t, relay_out, relay_m); end
      checks++; if (busy !== busy_m()) begin failures++; $display("FAIL %s_busy t=%0d got=%b exp=%b", name, t, busy, busy_m()); end
      if (relay_out === 1'b1 && first_high < 0) first_high = t;
      if (t >= 2 && t < 2 + 4 * hl && relay_out === 1'b1) high_run++;
      for (int k = 0; k < 8; k++)
        if (t == 2 + 4 * hl + k * hl + hl / 2) pat[7 - k] = relay_out;
      if (t == 2 + 12 * hl + hl / 2) ppat[1] = relay_out;
      if (t == 2 + 13 * hl + hl / 2) ppat[0] = relay_out;
      if (busy === 1'b0) begin fall = t; break; end
    end
    speed_sel = 1'b0;
    checks++; if (first_high != 2) begin failures++; $display("FAIL %s_latency got=%0d exp=2", name, first_high); end
    checks++; if (high_run != 4 * hl) begin failures++; $display("FAIL %s_sof_len got=%0d exp=%0d", name, high_run, 4 * hl); end
    checks++; if (pat !== exp_pat) begin failures++; $display("FAIL %s_data_pattern got=%b exp=%b", name, pat, exp_pat); end
    checks++; if (fall != 1 + HALF_TOTAL * hl) begin failures++; $display("FAIL %s_busy_fall got=%0d exp=%0d", name, fall, 1 + HALF_TOTAL * hl); end
`ifdef RELAY_TX_PARITY_EN
    checks++; if (ppat !== ((^sym) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL %s_parity_cells got=%b exp=%b", name, ppat, (^sym) ? 2'b10 : 2'b01); end
`endif
  endtask

  task automatic test_back_to_back();
    logic p;
    logic [3:0] syms[6];
    int sent, fall_at, gaps;
    logic seen_busy_low;
    sent = 0; fall_at = -1; gaps = 0;
    for (int i = 0; i < 6; i++) syms[i] = 4'($urandom);
    for (int t = 0; t < 2000; t++) begin
      data_in_valid = (sent < 6);
      data_in       = (sent < 6) ? syms[sent] : 4'h0;
      tick(p);
      if (p) sent++;
      checks++; if (relay_out !== relay_m) begin failures++; $display("FAIL b2b_relay t=%0d got=%b exp=%b", t, relay_out, relay_m); end
      checks++; if (data_in_ready !== ready_m()) begin failures++; $display("FAIL b2b_ready t=%0d got=%b exp=%b", t, data_in_ready, ready_m()); end
      checks++; if (busy !== busy_m()) begin failures++; $display("FAIL b2b_busy t=%0d got=%b exp=%b", t, busy, busy_m()); end
      if (data_in_ready === 1'b0 && fall_at < 0) fall_at = sent;
      if (sent == 6 && busy === 1'b0) break;
    end
    data_in_valid = 1'b0;
    seen_busy_low = (busy === 1'b0);
    checks++; if (sent != 6) begin failures++; $display("FAIL b2b_transfers got=%0d exp=6", sent); end
    checks++; if (fall_at != DEPTH + 1) begin failures++; $display("FAIL b2b_ready_fall_after got=%0d exp=%0d", fall_at, DEPTH + 1); end
    checks++; if (!seen_busy_low) begin failures++; $display("FAIL b2b_drain_timeout got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic p;
    data_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 4'(4'h9 + i);
      tick(p);
    end
    data_in_valid = 1'b0;
    for (int t = 0; t < 1 + 4 * H + 20; t++) begin
      tick(p);
      checks++; if (relay_out !== relay_m) begin failures++; $display("FAIL rstmid_relay t=%0d got=%b exp=%b", t, relay_out, relay_m); end
    end
    reset = 1'b1;
    #2;
    checks++; if (relay_out !== 1'b0) begin failures++; $display("FAIL rstmid_async_relay got=%b exp=0", relay_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_async_busy got=%b exp=0", busy); end
    checks++; if (data_in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_async_ready got=%b exp=1", data_in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int t = 0; t < 400; t++) begin
      tick(p);
      checks++; if (relay_out !== 1'b0) begin failures++; $display("FAIL rstmid_after_relay t=%0d got=%b exp=0", t, relay_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_after_busy t=%0d got=%b exp=0", t, busy); end
    end
  endtask

  task automatic test_random();
    logic p;
    for (int t = 0; t < 4000; t++) begin
      data_in_valid = ($urandom_range(0, 99) < 8);
      data_in       = 4'($urandom);
      speed_sel     = 1'($urandom);
      tick(p);
      checks++; if (relay_out !== relay_m) begin failures++; $display("FAIL rand_relay t=%0d got=%b exp=%b", t, relay_out, relay_m); end
      checks++; if (data_in_ready !== ready_m()) begin failures++; $display("FAIL rand_ready t=%0d got=%b exp=%b", t, data_in_ready, ready_m()); end
      checks++; if (busy !== busy_m()) begin failures++; $display("FAIL rand_busy t=%0d got=%b exp=%b", t, busy, busy_m()); end
    end
    data_in_valid = 1'b0;
    speed_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single("slow_a", 4'hA, 1'b0, 1'b0, 8'b1001_1001);
    test_single("fast_3", 4'h3, 1'b1, 1'b1, 8'b0101_1010);
`ifdef RELAY_TX_PARITY_EN
    test_single("par_7", 4'h7, 1'b0, 1'b0, 8'b0110_1010);
    test_single("par_5", 4'h5, 1'b0, 1'b0, 8'b0110_0110);
`endif
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
